gb_run_controller: RTL and testbench



---
 rtl/gb_run_controller.sv | 135 +++++++++++++
 tb/tb_gb_run_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gb_run_controller.sv
// Run/reset sequencer for the gameboy top: holds all core domains in reset, releases them
// one by one, counts run cycles and ends the run on a halt request or the cycle budget.
module gb_run_controller #(
   parameter int NUM_DOMAINS = 2,
   parameter int RESET_HOLD  = 4,
   parameter int STAGGER     = 2,
   parameter int CNT_W       = 16,
   parameter int MAX_CYCLES  = 200
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   halt_req,
   output logic [NUM_DOMAINS-1:0] core_reset,
   output logic                   running,
   output logic                   done,
   output logic                   timeout,
   output logic [CNT_W-1:0]       cycle_count
);

   localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGGER;
   localparam int HW       = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int SW       = $clog2(REL_LAST + 2);

   if (NUM_DOMAINS < 1 || RESET_HOLD < 1 || STAGGER < 1 || MAX_CYCLES < 0 ||
       (CNT_W < 31 && MAX_CYCLES >= (1 << CNT_W))) begin : g_param_check
      $error("gb_run_controller: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      RELEASE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   logic [HW-1:0]  hold_cnt;
   logic [SW-1:0]  stag_cnt;
   logic [SW-1:0]  stag_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign stag_next = stag_cnt + SW'(1);

   always_ff @(posedge clock) begin
      if (reset || abort) begin
         state       <= IDLE;
         core_reset  <= '1;
         running     <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         hold_cnt    <= '0;
         stag_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               core_reset <= '1;
               if (start) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end
            end

            HOLD: begin
               if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                  core_reset[0] <= 1'b0;
                  stag_cnt      <= '0;
                  if (NUM_DOMAINS == 1) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            RELEASE: begin
               // Domain k comes out of reset once k*STAGGER edges have passed since domain 0.
               stag_cnt <= stag_next;
               for (int k = 1; k < NUM_DOMAINS; k++) begin
                  if (stag_next == SW'(k * STAGGER))
                     core_reset[k] <= 1'b0;
               end
               if (stag_next == SW'(REL_LAST)) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end

            RUN: begin
               cycle_count <= sat_inc(cycle_count);
               if (halt_req) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  timeout <= 1'b0;
                  running <= 1'b0;
               end else if (MAX_CYCLES != 0 &&
                            cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  running <= 1'b0;
               end
            end

            DONE: begin
               // Domains stay released here so the core state can be inspected.
               if (start) begin
                  state       <= HOLD;
                  hold_cnt    <= '0;
                  core_reset  <= '1;
                  done        <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end

            default: begin
               state      <= IDLE;
               core_reset <= '1;
               running    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_run_controller.sv
// Scoreboard bench for gb_run_controller: a default instance plus a 3-domain, no-budget
// instance, with expected snapshots queued per clock edge and checked by a monitor.
module tb_gb_run_controller;

   logic clock;
   logic reset, start, abort, halt_req;
   logic [1:0]  core_reset;
   logic        running, done, timeout;
   logic [15:0] cycle_count;

   logic reset2, start2, abort2, halt_req2;
   logic [2:0]  core_reset2;
   logic        running2, done2, timeout2;
   logic [15:0] cycle_count2;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          tag;
      string       nm;
      logic [2:0]  cr;
      logic        run;
      logic        dn;
      logic        to;
      int          cnt;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   gb_run_controller dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .halt_req(halt_req),
      .core_reset(core_reset), .running(running), .done(done), .timeout(timeout),
      .cycle_count(cycle_count)
   );

   gb_run_controller #(
      .NUM_DOMAINS(3), .RESET_HOLD(4), .STAGGER(1), .CNT_W(16), .MAX_CYCLES(0)
   ) dut3 (
      .clock(clock), .reset(reset2), .start(start2), .abort(abort2), .halt_req(halt_req2),
      .core_reset(core_reset2), .running(running2), .done(done2), .timeout(timeout2),
      .cycle_count(cycle_count2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) edge_n <= edge_n + 1;

   task automatic go_to_edge(input int e);
      while (edge_n < e) @(negedge clock);
   endtask

   task automatic expect_at(input int which, input int tag, input string nm,
                            input logic [2:0] cr, input logic run, input logic dn,
                            input logic to, input int cnt);
      exp_t e;
      e.tag = tag; e.nm = nm; e.cr = cr; e.run = run; e.dn = dn; e.to = to; e.cnt = cnt;
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
   endtask

   task automatic compare(input exp_t e, input logic [2:0] cr, input logic run,
                          input logic dn, input logic to, input logic [15:0] cnt);
      checks++;
      if (e.tag != edge_n) begin
         errors++;
         $display("FAIL %s: check missed, scheduled edge %0d, now edge %0d", e.nm, e.tag, edge_n);
      end else if (cr !== e.cr || run !== e.run || dn !== e.dn || to !== e.to ||
                   cnt !== 16'(e.cnt)) begin
         errors++;
         $display("FAIL %s @edge %0d: got cr=%b run=%b done=%b to=%b cnt=%0d, want cr=%b run=%b done=%b to=%b cnt=%0d",
                  e.nm, edge_n, cr, run, dn, to, cnt, e.cr, e.run, e.dn, e.to, e.cnt);
      end
   endtask

   // Monitor: samples just after the falling edge, once the stimulus for this edge is queued.
   always @(negedge clock) begin
      #1;
      while (q1.size() > 0 && q1[0].tag <= edge_n) begin
         exp_t e;
         e = q1.pop_front();
         compare(e, {1'b0, core_reset}, running, done, timeout, cycle_count);
      end
      while (q2.size() > 0 && q2[0].tag <= edge_n) begin
         exp_t e;
         e = q2.pop_front();
         compare(e, core_reset2, running2, done2, timeout2, cycle_count2);
      end
   end

   always @(posedge clock) begin
      if (edge_n > 80000) begin
         errors++;
         $display("FAIL watchdog: edge %0d reached with %0d/%0d checks pending", edge_n,
                  q1.size(), q2.size());
         $display("Result: errors=%0d of %0d checks", errors, checks + 1);
         $finish;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; halt_req = 1'b0;
      reset2 = 1'b1; start2 = 1'b0; abort2 = 1'b0; halt_req2 = 1'b0;
      fork
         begin : default_instance
            int e0, s, t, u, v, w;
            go_to_edge(2);
            expect_at(1, 2, "reset_state", 3'b011, 0, 0, 0, 0);
            e0 = 3;
            for (int i = 0; i < 4; i++) expect_at(1, e0 + i, "hold", 3'b011, 0, 0, 0, 0);
            expect_at(1, e0 + 4,   "release0",     3'b010, 0, 0, 0, 0);
            expect_at(1, e0 + 5,   "release0_hold", 3'b010, 0, 0, 0, 0);
            expect_at(1, e0 + 6,   "run_entry",    3'b000, 1, 0, 0, 0);
            expect_at(1, e0 + 7,   "run_count1",   3'b000, 1, 0, 0, 1);
            expect_at(1, e0 + 20,  "start_in_run", 3'b000, 1, 0, 0, 14);
            expect_at(1, e0 + 21,  "after_start_in_run", 3'b000, 1, 0, 0, 15);
            expect_at(1, e0 + 205, "budget_minus1", 3'b000, 1, 0, 0, 199);
            expect_at(1, e0 + 206, "timeout",      3'b000, 0, 1, 1, 200);
            expect_at(1, e0 + 216, "timeout_hold10", 3'b000, 0, 1, 1, 200);
            expect_at(1, e0 + 226, "timeout_hold20", 3'b000, 0, 1, 1, 200);
            expect_at(1, e0 + 231, "halt_in_done", 3'b000, 0, 1, 1, 200);
            reset = 1'b0; start = 1'b1;
            go_to_edge(e0);       start = 1'b0;
            go_to_edge(e0 + 19);  start = 1'b1;
            go_to_edge(e0 + 20);  start = 1'b0;
            go_to_edge(e0 + 229); halt_req = 1'b1;
            go_to_edge(e0 + 230); halt_req = 1'b0;

            s = e0 + 235;
            expect_at(1, s,      "restart_clear", 3'b011, 0, 0, 0, 0);
            expect_at(1, s + 3,  "restart_hold",  3'b011, 0, 0, 0, 0);
            expect_at(1, s + 4,  "restart_rel0",  3'b010, 0, 0, 0, 0);
            expect_at(1, s + 6,  "restart_run",   3'b000, 1, 0, 0, 0);
            expect_at(1, s + 15, "pre_halt",      3'b000, 1, 0, 0, 9);
            expect_at(1, s + 16, "halt_done",     3'b000, 0, 1, 0, 10);
            expect_at(1, s + 21, "late_halt",     3'b000, 0, 1, 0, 10);
            go_to_edge(s - 1);  start = 1'b1;
            go_to_edge(s);      start = 1'b0;
            go_to_edge(s + 15); halt_req = 1'b1;
            go_to_edge(s + 16); halt_req = 1'b0;
            go_to_edge(s + 20); halt_req = 1'b1;
            go_to_edge(s + 21); halt_req = 1'b0;

            t = s + 25;
            expect_at(1, t,       "restart2_clear", 3'b011, 0, 0, 0, 0);
            expect_at(1, t + 205, "tie_minus1",     3'b000, 1, 0, 0, 199);
            expect_at(1, t + 206, "halt_wins_tie",  3'b000, 0, 1, 0, 200);
            expect_at(1, t + 207, "tie_stable",     3'b000, 0, 1, 0, 200);
            go_to_edge(t - 1);   start = 1'b1;
            go_to_edge(t);       start = 1'b0;
            go_to_edge(t + 205); halt_req = 1'b1;
            go_to_edge(t + 206); halt_req = 1'b0;

            u = t + 210;
            expect_at(1, u + 4,  "abort_pre",   3'b010, 0, 0, 0, 0);
            expect_at(1, u + 5,  "abort_idle",  3'b011, 0, 0, 0, 0);
            expect_at(1, u + 10, "abort_stays", 3'b011, 0, 0, 0, 0);
            go_to_edge(u - 1); start = 1'b1;
            go_to_edge(u);     start = 1'b0;
            go_to_edge(u + 4); abort = 1'b1;
            go_to_edge(u + 5); abort = 1'b0;

            v = u + 12;
            expect_at(1, v + 9,  "pre_reset_run", 3'b000, 1, 0, 0, 3);
            expect_at(1, v + 10, "reset_in_run",  3'b011, 0, 0, 0, 0);
            go_to_edge(v - 1);  start = 1'b1;
            go_to_edge(v);      start = 1'b0;
            go_to_edge(v + 9);  reset = 1'b1;
            go_to_edge(v + 10); reset = 1'b0;

            w = v + 12;
            expect_at(1, w + 4, "abort_beats_start", 3'b011, 0, 0, 0, 0);
            expect_at(1, w + 6, "abort_beats_start2", 3'b011, 0, 0, 0, 0);
            go_to_edge(w - 1); start = 1'b1; abort = 1'b1;
            go_to_edge(w);     start = 1'b0; abort = 1'b0;
            go_to_edge(w + 8);
         end
         begin : three_domain_instance
            go_to_edge(2);
            expect_at(2, 2, "d3_reset_state", 3'b111, 0, 0, 0, 0);
            for (int i = 3; i < 7; i++) expect_at(2, i, "d3_hold", 3'b111, 0, 0, 0, 0);
            expect_at(2, 7,     "d3_rel0",     3'b110, 0, 0, 0, 0);
            expect_at(2, 8,     "d3_rel1",     3'b100, 0, 0, 0, 0);
            expect_at(2, 9,     "d3_run",      3'b000, 1, 0, 0, 0);
            expect_at(2, 10,    "d3_count1",   3'b000, 1, 0, 0, 1);
            expect_at(2, 203,   "d3_no_budget", 3'b000, 1, 0, 0, 194);
            expect_at(2, 65543, "d3_pre_sat",  3'b000, 1, 0, 0, 65534);
            expect_at(2, 65544, "d3_sat",      3'b000, 1, 0, 0, 65535);
            expect_at(2, 70009, "d3_sat_hold", 3'b000, 1, 0, 0, 65535);
            reset2 = 1'b0; start2 = 1'b1;
            go_to_edge(3); start2 = 1'b0;
            go_to_edge(70010);
         end
      join
      go_to_edge(edge_n + 2);
      while (q1.size() > 0) begin
         checks++; errors++;
         $display("FAIL %s: never checked (edge %0d)", q1[0].nm, q1[0].tag);
         void'(q1.pop_front());
      end
      while (q2.size() > 0) begin
         checks++; errors++;
         $display("FAIL %s: never checked (edge %0d)", q2[0].nm, q2[0].tag);
         void'(q2.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
